vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Sequences port A of the 1K x 8 text video RAM (64x16 characters, pipelined read mode, power-up content 0x20).
- Shares the port between three requesters:
  - Z80 bus side: fixed-latency pulses.
  - ESP host side: valid/ready handshake.
  - Built-in fill engine: hardware clear-screen / fill with any character.
- Port B stays with the display scan-out and is outside this block.

Parameters:
- ADDR_W, 10, RAM address width; fill sweeps 0 .. 2**ADDR_W-1.
- RD_LAT, 3, cycles from accepted read request to rvalid (1 command register + 2 RAM pipeline stages).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- z80_req  in  1  single-cycle access strobe from Z80 decode.
- z80_we  in  1  1=write, 0=read; valid with z80_req.
- z80_addr  in  10  Z80 VRAM address.
- z80_wdata  in  8  Z80 write data.
- z80_rdata  out  8  Z80 read data.
- z80_rvalid  out  1  one-cycle pulse; z80_rdata valid.
- host_valid  in  1  host request pending; held until accepted.
- host_we  in  1  1=write, 0=read.
- host_addr  in  10  host address.
- host_wdata  in  8  host write data.
- host_ready  out  1  one-cycle accept pulse.
- host_rdata  out  8  host read data.
- host_rvalid  out  1  one-cycle pulse; host_rdata valid.
- fill_start  in  1  pulse; begin fill.
- fill_char  in  8  fill character; sampled on accepted fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last address is written.
- ram_ce  out  1  port A clock enable (registered).
- ram_oce  out  1  port A output enable; constant 1.
- ram_we  out  1  port A write enable (registered).
- ram_ad  out  10  port A address (registered).
- ram_din  out  8  port A write data (registered).
- ram_dout  in  8  port A read data (pipelined).

Behaviour:
- Reset: every output is 0 except ram_oce=1. State IDLE, fill counter 0, read-tag pipeline cleared. Reset mid-fill aborts the fill with no fill_done. Reset drops in-flight reads (no rvalid).
- Arbitration is evaluated each cycle with fixed priority Z80 > host > fill. The winner's command is registered onto ram_* the next cycle (ram_ce=1). With no winner: ram_ce=0, ram_we=0.
- Z80 path:
  - z80_req is always granted in its own cycle, never stalled or dropped.
  - Back-to-back z80_req pulses are all serviced.
- Host path:
  - Granted when host_valid=1 and z80_req=0.
  - host_ready pulses in the grant cycle.
  - The host must deassert or present a new request the following cycle.
  - host_valid held through Z80 traffic waits with no limit; the Z80 is the real-time master.
- Fill engine, states IDLE and FILL:
  - IDLE -> FILL on fill_start: latch fill_char, counter=0, fill_busy=1.
  - In FILL, the engine writes fill_char at the counter whenever neither Z80 nor host wins. The counter increments only on a granted slot.
  - A granted write at address 1023 -> IDLE, fill_busy=0, fill_done pulses on the following cycle.
  - fill_start while busy is ignored; the latched character is unchanged.
  - A Z80 or host write during a fill to an address below the counter persists. At or above the counter, the fill overwrites it later.
- Reads:
  - A 2-bit owner tag per stage (none/Z80/host) tracks each read through RD_LAT stages.
  - The matching rvalid pulses exactly RD_LAT cycles after the grant cycle, with rdata = ram_dout registered.
  - rdata holds its last value when rvalid=0.
  - Writes produce no rvalid. WRITE_MODE normal: the RAM output during a write is ignored (no tag).
- Simultaneous z80_req, host_valid and fill in the same cycle: the Z80 is served, then the host next cycle, then the fill resumes.

Test Plan:
- Reset, then fill_start with fill_char=0x2A and no other traffic -> 1024 consecutive ram_we cycles on addresses 0..1023. fill_done pulses 1025 cycles after the start cycle (1024 grants + 1). A read-back of any address returns 0x2A.
- Z80 write 0x41 to 0x005, then Z80 read of 0x005 on the next cycle -> z80_rvalid exactly 3 cycles after the read strobe, z80_rdata=0x41. host_rvalid stays 0.
- host_valid held (read of 0x3FF) while z80_req pulses on 4 consecutive cycles -> host_ready only in the 5th cycle, host_rvalid 3 cycles later. All 4 Z80 accesses appear first on ram_ad.
- During a fill at counter 0x100: Z80 write 0x55 to 0x080 and a host write 0x66 to 0x200 -> after fill_done, 0x080=0x55 and 0x200=fill_char. The fill length grows by exactly the 2 stolen cycles.
- Reset asserted at fill counter 0x1F0 -> next cycle fill_busy=0, ram_ce=0, no fill_done. A new fill_start restarts at address 0.
- fill_start pulsed again mid-fill with a different fill_char -> ignored; the completion time and the fill value are those of the original fill.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Port A sequencer for the 1K x 8 text VRAM: fixed-priority sharing between the Z80,
// the ESP host and a hardware fill engine, with owner tags steering pipelined read data.
module vram_port_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z80_req,
    input  logic              z80_we,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_wdata,
    output logic [7:0]        z80_rdata,
    output logic              z80_rvalid,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ready,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    input  logic              fill_start,
    input  logic [7:0]        fill_char,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic {StIdle, StFill} state_e;
    typedef enum logic [1:0] {TagNone = 2'd0, TagZ80 = 2'd1, TagHost = 2'd2} tag_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic [7:0]        fill_char_q;
    logic              fill_busy_q;
    logic              fill_done_q;

    logic              ram_ce_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_ad_q;
    logic [7:0]        ram_din_q;
    tag_e              tag_q [RD_LAT];
    logic [7:0]        z80_rdata_q;
    logic [7:0]        host_rdata_q;

    logic              z80_gnt;
    logic              host_gnt;
    logic              fill_gnt;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_ad;
    logic [7:0]        cmd_din;
    tag_e              tag_d;

    // Fixed priority: the Z80 can never be stalled, the fill only takes idle slots.
    always_comb begin
        z80_gnt  = z80_req & ~reset;
        host_gnt = host_valid & ~z80_req & ~reset;
        fill_gnt = (state_q == StFill) & ~z80_req & ~host_valid & ~reset;
        cmd_we   = 1'b0;
        cmd_ad   = fill_cnt_q;
        cmd_din  = fill_char_q;
        tag_d    = TagNone;
        if (z80_gnt) begin
            cmd_we  = z80_we;
            cmd_ad  = z80_addr;
            cmd_din = z80_wdata;
            if (!z80_we) tag_d = TagZ80;
        end else if (host_gnt) begin
            cmd_we  = host_we;
            cmd_ad  = host_addr;
            cmd_din = host_wdata;
            if (!host_we) tag_d = TagHost;
        end else if (fill_gnt) begin
            cmd_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fill_cnt_q  <= '0;
            fill_char_q <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fill_start) begin
                        state_q     <= StFill;
                        fill_char_q <= fill_char;
                        fill_cnt_q  <= '0;
                        fill_busy_q <= 1'b1;
                    end
                end
                StFill: begin
                    if (fill_gnt) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (&fill_cnt_q) begin
                            state_q     <= StIdle;
                            fill_busy_q <= 1'b0;
                            fill_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_ad_q     <= '0;
            ram_din_q    <= '0;
            z80_rdata_q  <= '0;
            host_rdata_q <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TagNone;
        end else begin
            ram_ce_q  <= z80_gnt | host_gnt | fill_gnt;
            ram_we_q  <= cmd_we;
            ram_ad_q  <= cmd_ad;
            ram_din_q <= cmd_din;
            tag_q[0]  <= tag_d;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (z80_rvalid) z80_rdata_q <= ram_dout;
            if (host_rvalid) host_rdata_q <= ram_dout;
        end
    end

    // The RAM output register is the last pipeline stage; hold registers keep rdata stable.
    assign z80_rvalid  = (tag_q[RD_LAT-1] == TagZ80);
    assign host_rvalid = (tag_q[RD_LAT-1] == TagHost);
    assign z80_rdata   = z80_rvalid ? ram_dout : z80_rdata_q;
    assign host_rdata  = host_rvalid ? ram_dout : host_rdata_q;
    assign host_ready  = host_gnt;
    assign fill_busy   = fill_busy_q;
    assign fill_done   = fill_done_q;
    assign ram_ce      = ram_ce_q;
    assign ram_oce     = 1'b1;
    assign ram_we      = ram_we_q;
    assign ram_ad      = ram_ad_q;
    assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: behavioural pipelined RAM on port A, read scoreboard,
// arbitration vector table and multi-cycle fill sequences.
module tb_vram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       z80_req, z80_we, z80_rvalid;
    logic [9:0] z80_addr;
    logic [7:0] z80_wdata, z80_rdata;
    logic       host_valid, host_we, host_ready, host_rvalid;
    logic [9:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       fill_start, fill_busy, fill_done;
    logic [7:0] fill_char;
    logic       ram_ce, ram_oce, ram_we;
    logic [9:0] ram_ad;
    logic [7:0] ram_din, ram_dout;

    vram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
        .z80_rdata(z80_rdata), .z80_rvalid(z80_rvalid),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .fill_start(fill_start), .fill_char(fill_char), .fill_busy(fill_busy),
        .fill_done(fill_done),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_we(ram_we), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Pipelined RAM: address stage then output register.
    logic [7:0] mem [1024];
    logic [7:0] stage_q = 8'h00;
    logic [7:0] dout_q = 8'h00;
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'h20;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_ad] <= ram_din;
            else stage_q <= mem[ram_ad];
        end
        dout_q <= stage_q;
    end
    assign ram_dout = dout_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] data; int due; } exp_t;
    exp_t z80_q[$];
    exp_t host_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (z80_q.size() > 0 && z80_q[0].due < cyc) begin
            chk("z80_rvalid_missing", 0, 1);
            void'(z80_q.pop_front());
        end
        if (host_q.size() > 0 && host_q[0].due < cyc) begin
            chk("host_rvalid_missing", 0, 1);
            void'(host_q.pop_front());
        end
        if (z80_rvalid) begin
            if (z80_q.size() == 0) chk("z80_rvalid_spurious", 1, 0);
            else begin
                e = z80_q.pop_front();
                chk("z80_rdata", z80_rdata, e.data);
                chk("z80_rvalid_cycle", cyc, e.due);
            end
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) chk("host_rvalid_spurious", 1, 0);
            else begin
                e = host_q.pop_front();
                chk("host_rdata", host_rdata, e.data);
                chk("host_rvalid_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        z80_req = 1'b0; z80_we = 1'b0; z80_addr = '0; z80_wdata = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        fill_start = 1'b0; fill_char = '0;
    endtask

    task automatic do_reset();
        tick(); idle(); reset = 1'b1;
        tick(); idle(); reset = 1'b1;
        tick(); idle();
    endtask

    task automatic drain();
        repeat (6) begin tick(); idle(); end
    endtask

    task automatic push_z80(input logic [7:0] d);
        exp_t e;
        e.data = d; e.due = cyc + 3;
        z80_q.push_back(e);
    endtask

    task automatic push_host(input logic [7:0] d, input int due);
        exp_t e;
        e.data = d; e.due = due;
        host_q.push_back(e);
    endtask

    task automatic z80_read(input logic [9:0] a, input logic [7:0] d);
        tick(); idle();
        z80_req = 1'b1; z80_addr = a;
        push_z80(d);
        tick(); idle();
    endtask

    task automatic host_read(input logic [9:0] a, input logic [7:0] d);
        tick(); idle();
        host_valid = 1'b1; host_addr = a;
        push_host(d, cyc + 3);
        tick(); idle();
    endtask

    // mode 0 plain, 1 Z80/host steal at counter 0x100, 2 repeated fill_start, 3 reset at 0x1F0
    task automatic fill_run(input logic [7:0] ch, input int mode, output int done_at,
                            output int nwe, output int seq_err);
        int exp_a;
        done_at = -1; nwe = 0; seq_err = 0; exp_a = 0;
        for (int j = 0; j < 1200; j++) begin
            tick(); idle();
            if (j == 0) begin fill_start = 1'b1; fill_char = ch; end
            if (mode == 1 && j == 257) begin
                z80_req = 1'b1; z80_we = 1'b1; z80_addr = 10'h080; z80_wdata = 8'h55;
            end
            if (mode == 1 && j == 258) begin
                host_valid = 1'b1; host_we = 1'b1; host_addr = 10'h200; host_wdata = 8'h66;
            end
            if (mode == 2 && j == 500) begin fill_start = 1'b1; fill_char = 8'h77; end
            if (mode == 3 && j == 497) reset = 1'b1;
            @(negedge clk);
            if (j == 1) chk("fill_busy_set", fill_busy, 1);
            if (mode == 1 && j == 258) chk("fill_host_ready", host_ready, 1);
            if (mode == 3 && j == 498) begin
                chk("rst_fill_busy", fill_busy, 0);
                chk("rst_ram_ce", ram_ce, 0);
            end
            if (ram_ce && ram_we) begin
                nwe++;
                if (ram_din == ch && ram_ad == exp_a[9:0]) exp_a++;
                else if (!(mode == 1 && (ram_din == 8'h55 || ram_din == 8'h66))) seq_err++;
            end
            if (fill_done && done_at < 0) done_at = j;
            if (done_at >= 0 && j > done_at + 3) break;
        end
    endtask

    typedef struct {
        logic zr, zw, hv, hw;
        logic exp_rdy, exp_ce, exp_we;
        logic [9:0] exp_ad;
        logic [7:0] exp_din;
        logic z_rd, h_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [9];
    int done_at, nwe, seq_err;

    initial begin
        // Z80 uses 0x111 / 0x5A, host uses 0x222 / 0xA5 throughout the table.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h111, 8'h00, 1'b1, 1'b0, 8'h20};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h222, 8'h00, 1'b0, 1'b1, 8'h20};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h111, 8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h222, 8'hA5, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h111, 8'h00, 1'b1, 1'b0, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h111, 8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h111, 8'h00, 1'b1, 1'b0, 8'h5A};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h222, 8'h00, 1'b0, 1'b1, 8'hA5};

        idle();
        do_reset();
        @(negedge clk);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_ad", ram_ad, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_ram_oce", ram_oce, 1);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_z80_rdata", z80_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_host_ready", host_ready, 0);

        for (int i = 0; i < 9; i++) begin
            tick(); idle();
            z80_req = vecs[i].zr; z80_we = vecs[i].zw;
            z80_addr = 10'h111; z80_wdata = 8'h5A;
            host_valid = vecs[i].hv; host_we = vecs[i].hw;
            host_addr = 10'h222; host_wdata = 8'hA5;
            if (vecs[i].z_rd) push_z80(vecs[i].exp_rd);
            if (vecs[i].h_rd) push_host(vecs[i].exp_rd, cyc + 3);
            @(negedge clk);
            chk("vec_host_ready", host_ready, vecs[i].exp_rdy);
            tick(); idle();
            @(negedge clk);
            chk("vec_ram_ce", ram_ce, vecs[i].exp_ce);
            chk("vec_ram_we", ram_we, vecs[i].exp_we);
            if (vecs[i].exp_ce) chk("vec_ram_ad", ram_ad, vecs[i].exp_ad);
            if (vecs[i].exp_we) chk("vec_ram_din", ram_din, vecs[i].exp_din);
        end
        drain();

        // Z80 write then immediate read-back of the same address.
        tick(); idle();
        z80_req = 1'b1; z80_we = 1'b1; z80_addr = 10'h005; z80_wdata = 8'h41;
        z80_read(10'h005, 8'h41);
        drain();
        @(negedge clk);
        chk("z80_rdata_hold", z80_rdata, 8'h41);
        chk("host_rdata_hold", host_rdata, 8'hA5);

        // Host read held through four back-to-back Z80 reads.
        for (int p = 0; p < 6; p++) begin
            tick(); idle();
            if (p < 5) begin host_valid = 1'b1; host_addr = 10'h3FF; end
            if (p < 4) begin
                z80_req = 1'b1; z80_addr = 10'(16 + p);
                push_z80(8'h20);
            end
            if (p == 0) push_host(8'h20, cyc + 7);
            @(negedge clk);
            chk("hold_host_ready", host_ready, (p == 4) ? 1 : 0);
            if (p > 0) chk("order_ram_ad", ram_ad, (p < 5) ? 15 + p : 1023);
        end
        drain();

        do_reset();
        fill_run(8'h2A, 0, done_at, nwe, seq_err);
        chk("fill0_done_at", done_at, 1025);
        chk("fill0_writes", nwe, 1024);
        chk("fill0_seq", seq_err, 0);
        chk("fill0_busy_end", fill_busy, 0);
        z80_read(10'h1A3, 8'h2A);
        host_read(10'h3FF, 8'h2A);
        drain();

        fill_run(8'h33, 1, done_at, nwe, seq_err);
        chk("fill1_done_at", done_at, 1027);
        chk("fill1_writes", nwe, 1026);
        chk("fill1_seq", seq_err, 0);
        z80_read(10'h080, 8'h55);
        host_read(10'h200, 8'h33);
        drain();

        fill_run(8'h44, 3, done_at, nwe, seq_err);
        chk("fill3_no_done", done_at, -1);
        chk("fill3_writes", nwe, 496);
        chk("fill3_seq", seq_err, 0);
        fill_run(8'h3C, 0, done_at, nwe, seq_err);
        chk("restart_done_at", done_at, 1025);
        chk("restart_seq", seq_err, 0);
        drain();

        fill_run(8'h11, 2, done_at, nwe, seq_err);
        chk("fill2_done_at", done_at, 1025);
        chk("fill2_writes", nwe, 1024);
        chk("fill2_seq", seq_err, 0);
        z80_read(10'h123, 8'h11);
        host_read(10'h3FF, 8'h11);
        drain();

        chk("z80_queue_empty", z80_q.size(), 0);
        chk("host_queue_empty", host_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
